// File: rtl/decoder_scan_sel.sv
// Scan select generator for a 3-to-8 decoder: blanked address changes, digit/frame strobes.
// Define SCAN_MASK_EN to let the mask input skip digits; otherwise every digit 0..LAST is scanned.
module decoder_scan_sel #(
    parameter int DIV   = 1000,
    parameter int BLANK = 4,
    parameter int LAST  = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] mask,
    output logic [2:0] A,
    output logic       E,
    output logic       step,
    output logic       frame
);

    localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_M1 = CW'(BLANK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    a_n;
    logic          e_n, step_n, frame_n;
    logic          start, start_n;
    logic          found, found_n;
    logic          wrap, wrap_n;

    logic [7:0]    en_vec;
    logic          hit;
    logic [2:0]    pick;
    int            base;
    int            idx;

`ifdef SCAN_MASK_EN
    assign en_vec = mask;
`else
    logic unused_mask;
    assign en_vec      = 8'hFF;
    assign unused_mask = ^mask;
`endif

    // First enabled index at or after the search base, wrapping within 0..LAST.
    always_comb begin
        hit  = 1'b0;
        pick = A;
        base = start ? 0 : int'(A) + 1;
        idx  = 0;
        for (int k = 0; k < 8; k++) begin
            idx = (base + k) % (LAST + 1);
            if (!hit && k <= LAST && en_vec[idx[2:0]]) begin
                hit  = 1'b1;
                pick = idx[2:0];
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = A;
        e_n     = 1'b0;
        step_n  = 1'b0;
        frame_n = 1'b0;
        start_n = start;
        found_n = found;
        wrap_n  = wrap;
        if (!run) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_n = S_BLANK;
                    cnt_n   = BLANK_M1;
                    start_n = 1'b1;
                end
                S_BLANK: begin
                    if (cnt == BLANK_M1) begin
                        found_n = hit;
                        wrap_n  = start | (pick <= A);
                        if (hit) a_n = pick;
                    end
                    if (cnt == '0) begin
                        cnt_n = BLANK_M1;
                        if (found) begin
                            state_n = S_SHOW;
                            cnt_n   = DIV_M1;
                            e_n     = 1'b1;
                            step_n  = 1'b1;
                            frame_n = wrap;
                            start_n = 1'b0;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_SHOW: begin
                    e_n = 1'b1;
                    if (cnt == '0) begin
                        state_n = S_BLANK;
                        cnt_n   = BLANK_M1;
                        e_n     = 1'b0;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            A     <= '0;
            E     <= 1'b0;
            step  <= 1'b0;
            frame <= 1'b0;
            start <= 1'b0;
            found <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            A     <= a_n;
            E     <= e_n;
            step  <= step_n;
            frame <= frame_n;
            start <= start_n;
            found <= found_n;
            wrap  <= wrap_n;
        end
    end

endmodule
